// File: rtl/ex_mem_pipe_reg.sv
// Execute-to-Memory pipeline register with a valid/ready handshake and a 2-entry skid buffer.
// Optional EX-stage forwarding taps are compiled in when EX_MEM_FWD_EN is defined.
module ex_mem_pipe_reg #(
    parameter int XLEN         = 32,
    parameter int REG_ADDR_W   = 5,
    parameter int RESULT_SRC_W = 2
) (
    input  logic                    clk,
    input  logic                    reset_n,
    input  logic                    flush,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [XLEN-1:0]         ALUResultE,
    input  logic [XLEN-1:0]         WriteDataE,
    input  logic [XLEN-1:0]         PCPlus4E,
    input  logic [REG_ADDR_W-1:0]   RdE,
    input  logic                    RegWriteE,
    input  logic [RESULT_SRC_W-1:0] ResultSrcE,
    input  logic                    MemWriteE,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [XLEN-1:0]         ALUResultM,
    output logic [XLEN-1:0]         WriteDataM,
    output logic [XLEN-1:0]         PCPlus4M,
    output logic [REG_ADDR_W-1:0]   RdM,
    output logic                    RegWriteM,
    output logic [RESULT_SRC_W-1:0] ResultSrcM,
    output logic                    MemWriteM,
`ifdef EX_MEM_FWD_EN
    output logic                    fwd_valid,
    output logic [REG_ADDR_W-1:0]   fwd_rd,
    output logic [XLEN-1:0]         fwd_data,
`endif
    output logic [1:0]              occupancy
);

    typedef struct packed {
        logic [XLEN-1:0]         alu_result;
        logic [XLEN-1:0]         write_data;
        logic [XLEN-1:0]         pc_plus4;
        logic [REG_ADDR_W-1:0]   rd;
        logic                    reg_write;
        logic [RESULT_SRC_W-1:0] result_src;
        logic                    mem_write;
    } entry_t;

    // Encoding doubles as the occupancy count.
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t state_p0;
    entry_t head_p0;
    entry_t skid_p1;
    entry_t in_entry;
    logic   in_ready_p0;
    logic   vld_p0;
    logic   accept;
    logic   pop;

    assign in_entry = '{
        alu_result: ALUResultE,
        write_data: WriteDataE,
        pc_plus4:   PCPlus4E,
        rd:         RdE,
        reg_write:  RegWriteE,
        result_src: ResultSrcE,
        mem_write:  MemWriteE
    };

    assign accept = in_valid & in_ready_p0;
    assign pop    = vld_p0 & out_ready;

    // Stage boundary: execute inputs -> head/skid registers
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_p0    <= EMPTY;
            in_ready_p0 <= 1'b1;
            vld_p0      <= 1'b0;
            head_p0     <= '0;
            skid_p1     <= '0;
        end else if (flush) begin
            // Kill side effects only; stale data fields are harmless once invalid.
            state_p0          <= EMPTY;
            in_ready_p0       <= 1'b1;
            vld_p0            <= 1'b0;
            head_p0.reg_write <= 1'b0;
            head_p0.mem_write <= 1'b0;
            skid_p1.reg_write <= 1'b0;
            skid_p1.mem_write <= 1'b0;
        end else begin
            case (state_p0)
                EMPTY: begin
                    if (accept) begin
                        head_p0  <= in_entry;
                        vld_p0   <= 1'b1;
                        state_p0 <= FULL;
                    end
                end
                FULL: begin
                    if (accept && pop) begin
                        head_p0 <= in_entry;
                    end else if (accept) begin
                        skid_p1     <= in_entry;
                        in_ready_p0 <= 1'b0;
                        state_p0    <= SKID;
                    end else if (pop) begin
                        vld_p0   <= 1'b0;
                        state_p0 <= EMPTY;
                    end
                end
                SKID: begin
                    if (pop) begin
                        head_p0     <= skid_p1;
                        in_ready_p0 <= 1'b1;
                        state_p0    <= FULL;
                    end
                end
                default: begin
                    state_p0    <= EMPTY;
                    in_ready_p0 <= 1'b1;
                    vld_p0      <= 1'b0;
                end
            endcase
        end
    end

    // Stage boundary: head register -> memory stage
    assign in_ready   = in_ready_p0;
    assign out_valid  = vld_p0;
    assign occupancy  = state_p0;
    assign ALUResultM = head_p0.alu_result;
    assign WriteDataM = head_p0.write_data;
    assign PCPlus4M   = head_p0.pc_plus4;
    assign RdM        = head_p0.rd;
    assign ResultSrcM = head_p0.result_src;
    assign RegWriteM  = head_p0.reg_write & vld_p0;
    assign MemWriteM  = head_p0.mem_write & vld_p0;

`ifdef EX_MEM_FWD_EN
    // Only plain ALU results can be forwarded; loads and PC+4 resolve later.
    assign fwd_valid = vld_p0 & head_p0.reg_write & (head_p0.rd != '0) &
                       (head_p0.result_src == '0);
    assign fwd_rd    = head_p0.rd;
    assign fwd_data  = head_p0.alu_result;
`endif

endmodule
